// File: rtl/n_bit_comparator_if.sv
// n_bit_comparator_if: operand/result bundle for n_bit_comparator.
// diff exists only when CMP_DIFF_EN is defined.
interface n_bit_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             Lesser;
  logic             Greater;
  logic             Equal;
`ifdef CMP_DIFF_EN
  logic [WIDTH-1:0] diff;

  modport master (
    output in_valid, a, b,
    input  out_valid, Lesser, Greater, Equal, diff
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, Lesser, Greater, Equal, diff
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, Lesser, Greater, Equal
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, Lesser, Greater, Equal
  );
`endif
endinterface

// File: rtl/n_bit_comparator.sv
// n_bit_comparator: registered a/b compare, 1-cycle latency, flags hold when idle.
// Optional registered |a-b| on diff when CMP_DIFF_EN is defined.
module n_bit_comparator #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic               clk,
  input logic               rst,
  n_bit_comparator_if.slave bus
);
  localparam int W1 = WIDTH + 1;

  logic          ext_a;
  logic          ext_b;
  logic [W1-1:0] ax;
  logic [W1-1:0] bx;
  logic [W1-1:0] sub;
  logic          lt;
  logic          eq;
  logic          gt;

  // One extra bit keeps a - b exact in both modes, so its sign is a < b.
  assign ext_a = SIGNED_CMP ? bus.a[WIDTH-1] : 1'b0;
  assign ext_b = SIGNED_CMP ? bus.b[WIDTH-1] : 1'b0;
  assign ax    = {ext_a, bus.a};
  assign bx    = {ext_b, bus.b};
  assign sub   = ax - bx;
  assign eq    = (ax == bx);
  assign lt    = sub[W1-1];
  assign gt    = ~lt & ~eq;

`ifdef CMP_DIFF_EN
  logic [W1-1:0]    mag;
  logic [WIDTH-1:0] dnext;

  assign mag   = lt ? (bx - ax) : sub;
  assign dnext = mag[W1-1] ? '1 : mag[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.diff <= '0;
    end else if (bus.in_valid) begin
      bus.diff <= dnext;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.Lesser    <= 1'b0;
      bus.Greater   <= 1'b0;
      bus.Equal     <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Lesser  <= lt;
        bus.Greater <= gt;
        bus.Equal   <= eq;
      end
    end
  end
endmodule

// File: tb/tb_n_bit_comparator.sv
// tb_n_bit_comparator: directed table, hold/reset sequences and random
// pairs against unsigned and signed instances driven in lockstep.
module tb_n_bit_comparator;
  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n_bit_comparator_if #(.WIDTH(32)) ifu ();
  n_bit_comparator_if #(.WIDTH(32)) ifs ();

  n_bit_comparator #(.WIDTH(32), .SIGNED_CMP(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifu)
  );

  n_bit_comparator #(.WIDTH(32), .SIGNED_CMP(1'b1)) s_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  u_lge;
    logic [2:0]  s_lge;
    logic [31:0] u_d;
    logic [31:0] s_d;
  } vec_t;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;
  localparam logic [2:0] NO = 3'b000;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b);
    ifu.in_valid = v;
    ifu.a        = a;
    ifu.b        = b;
    ifs.in_valid = v;
    ifs.a        = a;
    ifs.b        = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u(input string tag, input logic ov,
                       input logic [2:0] lge, input logic [31:0] d);
    chk({tag, " u.ov"}, 64'(ifu.out_valid), 64'(ov));
    chk({tag, " u.lge"},
        64'({ifu.Lesser, ifu.Greater, ifu.Equal}), 64'(lge));
`ifdef CMP_DIFF_EN
    chk({tag, " u.diff"}, 64'(ifu.diff), 64'(d));
`else
    if (d === 32'hx) $display("unused %0h", d);
`endif
  endtask

  task automatic chk_s(input string tag, input logic ov,
                       input logic [2:0] lge, input logic [31:0] d);
    chk({tag, " s.ov"}, 64'(ifs.out_valid), 64'(ov));
    chk({tag, " s.lge"},
        64'({ifs.Lesser, ifs.Greater, ifs.Equal}), 64'(lge));
`ifdef CMP_DIFF_EN
    chk({tag, " s.diff"}, 64'(ifs.diff), 64'(d));
`else
    if (d === 32'hx) $display("unused %0h", d);
`endif
  endtask

  initial begin
    vt[0]  = '{32'd2, 32'd2, EQ, EQ, 32'd0, 32'd0};
    vt[1]  = '{32'd22, 32'd444, LT, LT, 32'd422, 32'd422};
    vt[2]  = '{32'd444, 32'd555, LT, LT, 32'd111, 32'd111};
    vt[3]  = '{32'd777, 32'd111, GT, GT, 32'd666, 32'd666};
    vt[4]  = '{32'd8888, 32'd8888, EQ, EQ, 32'd0, 32'd0};
    vt[5]  = '{32'h0, 32'hFFFF_FFFF, LT, GT,
               32'hFFFF_FFFF, 32'd1};
    vt[6]  = '{32'hFFFF_FFFF, 32'd1, GT, LT,
               32'hFFFF_FFFE, 32'd2};
    vt[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, GT, LT,
               32'd1, 32'hFFFF_FFFF};
    vt[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, EQ, EQ, 32'd0, 32'd0};
    vt[9]  = '{32'h8000_0000, 32'h8000_0000, EQ, EQ, 32'd0, 32'd0};
    vt[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, EQ, EQ, 32'd0, 32'd0};
    vt[11] = '{32'h0, 32'h0, EQ, EQ, 32'd0, 32'd0};

    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    step();
    step();
    chk_u("reset", 1'b0, NO, 32'd0);
    chk_s("reset", 1'b0, NO, 32'd0);

    // Back-to-back table vectors
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vt[i].a, vt[i].b);
      step();
      chk_u($sformatf("vec%0d", i), 1'b1, vt[i].u_lge, vt[i].u_d);
      chk_s($sformatf("vec%0d", i), 1'b1, vt[i].s_lge, vt[i].s_d);
    end

    // Hold while idle, operand bus changing underneath
    drive(1'b1, 32'd5, 32'd3);
    step();
    chk_u("hold0", 1'b1, GT, 32'd2);
    chk_s("hold0", 1'b1, GT, 32'd2);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 32'd0, 32'd9 + 32'(i));
      step();
      chk_u($sformatf("hold%0d", i), 1'b0, GT, 32'd2);
      chk_s($sformatf("hold%0d", i), 1'b0, GT, 32'd2);
    end

    // Reset beats a valid operand pair, then operands accepted right after
    rst = 1'b1;
    drive(1'b1, 32'd9, 32'd9);
    step();
    chk_u("rstpri", 1'b0, NO, 32'd0);
    chk_s("rstpri", 1'b0, NO, 32'd0);
    drive(1'b1, 32'd1, 32'd7);
    step();
    chk_u("rsthold", 1'b0, NO, 32'd0);
    chk_s("rsthold", 1'b0, NO, 32'd0);
    rst = 1'b0;
    drive(1'b1, 32'd9, 32'd9);
    step();
    chk_u("postrst", 1'b1, EQ, 32'd0);
    chk_s("postrst", 1'b1, EQ, 32'd0);

    // Random pairs, both modes each cycle
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  eu;
      logic [2:0]  es;
      logic [31:0] du;
      logic [31:0] ds;
      longint      sa;
      longint      sb;
      ra = $urandom();
      rb = (i % 8 == 0) ? ra : $urandom();
      if (i % 16 == 3) rb = ra ^ 32'h8000_0000;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      eu = (ra < rb) ? LT : (ra > rb) ? GT : EQ;
      es = (sa < sb) ? LT : (sa > sb) ? GT : EQ;
      du = (ra > rb) ? ra - rb : rb - ra;
      ds = (sa > sb) ? 32'(sa - sb) : 32'(sb - sa);
      drive(1'b1, ra, rb);
      step();
      if ({ifu.out_valid, ifu.Lesser, ifu.Greater, ifu.Equal}
          !== {1'b1, eu}) begin
        chk($sformatf("rnd%0d u.lge", i),
            64'({ifu.out_valid, ifu.Lesser, ifu.Greater, ifu.Equal}),
            64'({1'b1, eu}));
      end else begin
        checks++;
      end
      if ({ifs.out_valid, ifs.Lesser, ifs.Greater, ifs.Equal}
          !== {1'b1, es}) begin
        chk($sformatf("rnd%0d s.lge", i),
            64'({ifs.out_valid, ifs.Lesser, ifs.Greater, ifs.Equal}),
            64'({1'b1, es}));
      end else begin
        checks++;
      end
`ifdef CMP_DIFF_EN
      if (ifu.diff !== du) chk($sformatf("rnd%0d u.diff", i),
                               64'(ifu.diff), 64'(du));
      if (ifs.diff !== ds) chk($sformatf("rnd%0d s.diff", i),
                               64'(ifs.diff), 64'(ds));
`else
      if (du === 32'hx || ds === 32'hx) $display("unused");
`endif
    end

    drive(1'b0, 32'd0, 32'd0);
    step();
    chk_u("tail", 1'b0, NO | {ifu.Lesser, ifu.Greater, ifu.Equal}, 32'd0
`ifndef CMP_DIFF_EN
    );
`else
    | ifu.diff);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
